// File: rtl/mont_exp_core.sv
// mont_exp_core: Montgomery modular exponentiation, o_result = i_a^i_d mod i_n.
//
// Ports:
//   i_clk    - clock; all state changes on the rising edge
//   i_rst    - synchronous active-high reset; overrides every other input
//   i_start  - start request, accepted only while o_ready=1
//   o_ready  - engine idle and able to accept a request
//   i_a      - base, sampled on accept
//   i_d      - exponent, sampled on accept
//   i_n      - odd modulus, sampled on accept
//   i_abort  - cancels a running operation (ignored when idle or done)
//   o_valid  - o_result/o_err valid; held until i_ack
//   i_ack    - consumes the result while o_valid=1
//   o_result - a^d mod n, or 0 when the inputs were rejected
//   o_err    - inputs rejected (n even, n<3 or a>=n)
//
// Flow: S_PREP maps a into the Montgomery domain (t = a*2^WIDTH mod n) by
// repeated doubling.  S_MONT walks the exponent LSB first.  m is kept in the
// plain domain, so MONT(m, t) = m*a and the final m needs no conversion back.
// The square unit and the multiply unit share the iteration counter and both
// read the m/t registers, which only change on the final-subtract cycle.
module mont_exp_core #(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [EXP_WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0]     i_n,
  input  logic                 i_abort,
  output logic                 o_valid,
  input  logic                 i_ack,
  output logic [WIDTH-1:0]     o_result,
  output logic                 o_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = $clog2(EXP_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_MONT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [EXP_WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]       t_q, t_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH+1:0]     acc_m_q, acc_m_d;
  logic [WIDTH+1:0]     acc_t_q, acc_t_d;
  logic [CW-1:0]        iter_q, iter_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic                 bad_in_s;
  logic [BW-1:0]        len_s;
  logic [WIDTH-1:0]     m_fin_s;

  // One radix-2 Montgomery step: acc = (acc + xb*y + q*n) / 2.
  // With acc < 2n and y < n the sum stays below 4n, so WIDTH+2 bits suffice.
  function automatic logic [WIDTH+1:0] mont_step(input logic [WIDTH+1:0] acc,
                                                 input logic xb,
                                                 input logic [WIDTH:0] y,
                                                 input logic [WIDTH-1:0] n);
    logic [WIDTH+1:0] s;
    s = acc + (xb ? {1'b0, y} : {(WIDTH+2){1'b0}});
    if (s[0]) begin
      s = s + {2'b00, n};
    end else begin
      s = s;
    end
    return s >> 1;
  endfunction

  // Final reduction of a Montgomery product (< 2n) into [0, n).
  function automatic logic [WIDTH-1:0] cond_sub(input logic [WIDTH+1:0] acc,
                                                input logic [WIDTH-1:0] n);
    logic [WIDTH+1:0] s;
    if (acc >= {2'b00, n}) begin
      s = acc - {2'b00, n};
    end else begin
      s = acc;
    end
    return s[WIDTH-1:0];
  endfunction

  // Modular doubling used to build a*2^WIDTH mod n.
  function automatic logic [WIDTH:0] mod_dbl(input logic [WIDTH:0] t,
                                             input logic [WIDTH-1:0] n);
    logic [WIDTH+1:0] s;
    s = {t, 1'b0};
    if (s >= {2'b00, n}) begin
      s = s - {2'b00, n};
    end else begin
      s = s;
    end
    return s[WIDTH:0];
  endfunction

  assign bad_in_s = ~i_n[0] | (i_n < WIDTH'(32'd3)) | (i_a >= i_n);
  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = valid_q;
  assign o_err    = err_q;
  assign o_result = result_q;

  // Significant exponent length: one plus the index of the highest set bit.
  always_comb begin
    len_s = {BW{1'b0}};
    for (int k = 0; k < EXP_WIDTH; k++) begin
      if (d_q[k]) begin
        len_s = BW'(k + 1);
      end else begin
        len_s = len_s;
      end
    end
  end

  // Multiply result for the current exponent bit (m unchanged when the bit is 0).
  always_comb begin
    if (d_q[bit_q]) begin
      m_fin_s = cond_sub(acc_m_q, n_q);
    end else begin
      m_fin_s = m_q;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    d_d      = d_q;
    t_d      = t_q;
    m_d      = m_q;
    acc_m_d  = acc_m_q;
    acc_t_d  = acc_t_q;
    iter_d   = iter_q;
    bit_d    = bit_q;
    valid_d  = valid_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && bad_in_s) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          err_d    = 1'b1;
          result_d = {WIDTH{1'b0}};
        end else if (i_start) begin
          state_d = S_PREP;
          n_d     = i_n;
          d_d     = i_d;
          t_d     = {1'b0, i_a};
          iter_d  = {CW{1'b0}};
          bit_d   = {BW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (iter_q == CW'(WIDTH)) begin
          // Conversion finished; d==0 has nothing to multiply and returns 1.
          iter_d  = {CW{1'b0}};
          bit_d   = {BW{1'b0}};
          acc_m_d = {(WIDTH+2){1'b0}};
          acc_t_d = {(WIDTH+2){1'b0}};
          m_d     = {{(WIDTH-1){1'b0}}, 1'b1};
          if (len_s == {BW{1'b0}}) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            err_d    = 1'b0;
            result_d = {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            state_d = S_MONT;
          end
        end else begin
          t_d    = mod_dbl(t_q, n_q);
          iter_d = iter_q + CW'(1);
        end
      end
      S_MONT: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (iter_q == CW'(WIDTH)) begin
          // Final-subtract cycle: commit both products and move to the next bit.
          t_d     = {1'b0, cond_sub(acc_t_q, n_q)};
          m_d     = m_fin_s;
          acc_m_d = {(WIDTH+2){1'b0}};
          acc_t_d = {(WIDTH+2){1'b0}};
          iter_d  = {CW{1'b0}};
          if (bit_q == len_s - BW'(1)) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            err_d    = 1'b0;
            result_d = m_fin_s;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          acc_m_d = mont_step(acc_m_q, m_q[iter_q], t_q, n_q);
          acc_t_d = mont_step(acc_t_q, t_q[iter_q], t_q, n_q);
          iter_d  = iter_q + CW'(1);
        end
      end
      S_DONE: begin
        // Only an acknowledge leaves S_DONE; abort is ignored here.
        if (i_ack) begin
          state_d  = S_IDLE;
          valid_d  = 1'b0;
          err_d    = 1'b0;
          result_d = {WIDTH{1'b0}};
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      n_q      <= {WIDTH{1'b0}};
      d_q      <= {EXP_WIDTH{1'b0}};
      t_q      <= {(WIDTH+1){1'b0}};
      m_q      <= {WIDTH{1'b0}};
      acc_m_q  <= {(WIDTH+2){1'b0}};
      acc_t_q  <= {(WIDTH+2){1'b0}};
      iter_q   <= {CW{1'b0}};
      bit_q    <= {BW{1'b0}};
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      d_q      <= d_d;
      t_q      <= t_d;
      m_q      <= m_d;
      acc_m_q  <= acc_m_d;
      acc_t_q  <= acc_t_d;
      iter_q   <= iter_d;
      bit_q    <= bit_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mont_exp_core.sv
// tb_mont_exp_core: drives an 8-bit engine with directed and random requests
// and the default 256-bit engine with random requests; results, error flags
// and latencies are compared against a plain-arithmetic square-and-multiply
// model using % on wide integers.
module tb_mont_exp_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       st8 = 1'b0, ab8 = 1'b0, ak8 = 1'b0;
  logic [7:0] a8 = 8'd0, d8 = 8'd0, n8 = 8'd0;
  logic       rdy8, v8, e8;
  logic [7:0] r8;

  // 256-bit instance
  logic         st2 = 1'b0, ab2 = 1'b0, ak2 = 1'b0;
  logic [255:0] a2 = '0, d2 = '0, n2 = '0;
  logic         rdy2, v2, e2;
  logic [255:0] r2;

  int n_checks = 0;
  int n_errors = 0;

  mont_exp_core #(.WIDTH(8), .EXP_WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(st8), .o_ready(rdy8),
    .i_a(a8), .i_d(d8), .i_n(n8), .i_abort(ab8),
    .o_valid(v8), .i_ack(ak8), .o_result(r8), .o_err(e8)
  );

  mont_exp_core u_dut256 (
    .i_clk(clk), .i_rst(rst), .i_start(st2), .o_ready(rdy2),
    .i_a(a2), .i_d(d2), .i_n(n2), .i_abort(ab2),
    .o_valid(v2), .i_ack(ak2), .o_result(r2), .o_err(e2)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden model: a^d mod n by square-and-multiply on plain integers.
  function automatic logic [255:0] ref_pow(input logic [255:0] a, input logic [255:0] d,
                                           input logic [255:0] n);
    logic [511:0] r, b, nn;
    nn = {256'd0, n};
    r  = 512'd1 % nn;
    b  = {256'd0, a} % nn;
    for (int i = 0; i < 256; i++) begin
      if (d[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[255:0];
  endfunction

  function automatic int ref_len(input logic [255:0] d);
    int l = 0;
    for (int i = 0; i < 256; i++) if (d[i]) l = i + 1;
    return l;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expected outcome of one request: error flag, result, latency after accept.
  task automatic expect_op(input logic [255:0] a, input logic [255:0] d, input logic [255:0] n,
                           input int w, output logic err, output logic [255:0] res, output int lat);
    if (n[0] == 1'b0 || n < 256'd3 || a >= n) begin
      err = 1'b1; res = '0; lat = 0;
    end else begin
      err = 1'b0; res = ref_pow(a, d, n); lat = 1 + w + ref_len(d) * (w + 1);
    end
  endtask

  // Runs one 8-bit request. kill_at/poke_at name the edge (counted after the
  // accepting edge) that samples abort-or-reset / a stray start; 0 disables.
  task automatic op8(input logic [7:0] a, input logic [7:0] d, input logic [7:0] n,
                     input int kill_at, input bit kill_rst, input int poke_at,
                     output int lat, output logic [7:0] res, output logic err);
    lat = -1; res = 8'd0; err = 1'b0;
    @(negedge clk);
    a8 = a; d8 = d; n8 = n; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0; a8 = 8'($urandom); d8 = 8'($urandom); n8 = 8'($urandom);
    if (v8) begin
      lat = 0; res = r8; err = e8;
    end else begin
      for (int k = 1; k <= 200; k++) begin
        if (k == kill_at) begin
          if (kill_rst) rst = 1'b1; else ab8 = 1'b1;
        end
        if (k == poke_at) st8 = 1'b1;
        @(negedge clk);
        ab8 = 1'b0; st8 = 1'b0;
        if (kill_rst && k == kill_at) begin
          rst = 1'b0;
          check_eq("rst_ready", 256'(rdy8), 256'd1);
          check_eq("rst_valid", 256'(v8), 256'd0);
          check_eq("rst_result", 256'(r8), 256'd0);
        end
        if (v8) begin
          lat = k; res = r8; err = e8;
          break;
        end
      end
    end
  endtask

  // Holds the result for 'hold' cycles, then acknowledges it.
  task automatic ack8(input int hold, input logic [7:0] res);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("hold_valid", 256'(v8), 256'd1);
      check_eq("hold_result", 256'(r8), 256'(res));
    end
    ak8 = 1'b1;
    @(negedge clk);
    ak8 = 1'b0;
    check_eq("ack_valid", 256'(v8), 256'd0);
    check_eq("ack_ready", 256'(rdy8), 256'd1);
    check_eq("ack_result", 256'(r8), 256'd0);
    check_eq("ack_err", 256'(e8), 256'd0);
  endtask

  // Runs, checks and acknowledges one 8-bit request with no disturbance.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] n, input int hold);
    logic [255:0] eres; logic eerr; int elat;
    int lat; logic [7:0] res; logic err;
    expect_op(256'(a), 256'(d), 256'(n), 8, eerr, eres, elat);
    op8(a, d, n, 0, 1'b0, 0, lat, res, err);
    check_eq({tag, "_lat"}, 256'(lat), 256'(elat));
    check_eq({tag, "_res"}, 256'(res), eres);
    check_eq({tag, "_err"}, 256'(err), 256'(eerr));
    if (lat >= 0) ack8(hold, res);
  endtask

  task automatic run256(input logic [255:0] a, input logic [255:0] d, input logic [255:0] n);
    logic [255:0] eres; logic eerr; int elat;
    int lat; logic [255:0] res; logic err;
    expect_op(a, d, n, 256, eerr, eres, elat);
    lat = -1; res = '0; err = 1'b0;
    @(negedge clk);
    a2 = a; d2 = d; n2 = n; st2 = 1'b1;
    @(negedge clk);
    st2 = 1'b0; a2 = rand256(); d2 = rand256(); n2 = rand256();
    if (v2) begin
      lat = 0; res = r2; err = e2;
    end else begin
      for (int k = 1; k <= 5000; k++) begin
        @(negedge clk);
        if (v2) begin
          lat = k; res = r2; err = e2;
          break;
        end
      end
    end
    check_eq("w256_lat", 256'(lat), 256'(elat));
    check_eq("w256_res", res, eres);
    check_eq("w256_err", 256'(err), 256'(eerr));
    ak2 = 1'b1;
    @(negedge clk);
    ak2 = 1'b0;
    check_eq("w256_ack_valid", 256'(v2), 256'd0);
    check_eq("w256_ack_ready", 256'(rdy2), 256'd1);
  endtask

  initial begin
    int lat; logic [7:0] res; logic err;
    logic [7:0] n, a;
    logic [255:0] bn, ba;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ready8", 256'(rdy8), 256'd1);
    check_eq("reset_valid8", 256'(v8), 256'd0);
    check_eq("reset_result8", 256'(r8), 256'd0);
    check_eq("reset_err8", 256'(e8), 256'd0);
    check_eq("reset_ready256", 256'(rdy2), 256'd1);
    check_eq("reset_valid256", 256'(v2), 256'd0);

    // Directed cases from the reference exponentiations.
    run8("case1", 8'd88, 8'd7, 8'd187, 0);
    check_eq("case1_const", 256'(ref_pow(256'd88, 256'd7, 256'd187)), 256'd11);
    run8("case2", 8'd11, 8'd23, 8'd187, 5);
    run8("d_zero", 8'd5, 8'd0, 8'd187, 0);
    run8("n_even", 8'd5, 8'd3, 8'd186, 2);
    run8("a_big", 8'd200, 8'd3, 8'd187, 0);
    run8("n_one", 8'd0, 8'd3, 8'd1, 0);
    run8("a_eq_n", 8'd187, 8'd3, 8'd187, 0);
    run8("d_max", 8'd2, 8'd255, 8'd255, 0);

    // Abort at edge 20 (inside the exponent loop), then the same request again.
    op8(8'd88, 8'd7, 8'd187, 20, 1'b0, 0, lat, res, err);
    check_eq("abort_no_valid", 256'(lat), 256'(-1));
    check_eq("abort_ready", 256'(rdy8), 256'd1);
    run8("after_abort", 8'd88, 8'd7, 8'd187, 0);

    // Stray start mid-run must not restart or relatch.
    op8(8'd88, 8'd7, 8'd187, 0, 1'b0, 10, lat, res, err);
    check_eq("poke_lat", 256'(lat), 256'd36);
    check_eq("poke_res", 256'(res), 256'd11);
    ack8(0, res);

    // Reset inside the exponent loop, then a normal run.
    op8(8'd88, 8'd7, 8'd187, 20, 1'b1, 0, lat, res, err);
    check_eq("rst_no_valid", 256'(lat), 256'(-1));
    run8("after_rst", 8'd88, 8'd7, 8'd187, 0);

    // Random 8-bit requests, a quarter with unconstrained (possibly invalid) inputs.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = 8'($urandom); a = 8'($urandom);
      end else begin
        n = 8'($urandom_range(1, 127) * 2 + 1);
        a = 8'($urandom_range(0, int'(n) - 1));
      end
      run8("rand8", a, 8'($urandom), n, $urandom_range(0, 2));
    end

    // Random 256-bit requests with short exponents to bound run time.
    run256(256'd5, 256'd0, 256'd187);
    for (int i = 0; i < 8; i++) begin
      bn = rand256() | 256'd1;
      if (bn < 256'd3) bn = 256'd3;
      ba = rand256() % bn;
      run256(ba, 256'($urandom_range(1, 4095)), bn);
    end
    bn = rand256() & ~256'd1;
    run256(256'd7, 256'd9, bn);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
